// File: rtl/ahb_mux_m2s_param.sv
// ahb_mux_m2s_param: parametrised AHB master-to-slave multiplexer.
// The address-phase master (HMASTER) drives the address/control outputs
// combinationally. The data-phase owner (HMASTERD) is registered on
// HREADY and steers HWDATA. An out-of-range select falls back to
// DEFAULT_MASTER with HTRANS forced to IDLE, and raises a one-cycle HSELERR.
// Optional feature: define AHB_M2S_LOCK_EN to add HMASTLOCKx/HMASTLOCK/HMASTLOCKD.
module ahb_mux_m2s_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 1,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MASTER_W       = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_MASTERS*ADDR_W-1:0] HADDRx,
  input  logic [NUM_MASTERS-1:0]        HWRITEx,
  input  logic [NUM_MASTERS*2-1:0]      HTRANSx,
  input  logic [NUM_MASTERS*3-1:0]      HSIZEx,
  input  logic [NUM_MASTERS*3-1:0]      HBURSTx,
  input  logic [NUM_MASTERS*DATA_W-1:0] HWDATAx,
  input  logic [MASTER_W-1:0]           HMASTER,
  input  logic                          HREADY,
  output logic [ADDR_W-1:0]             HADDR,
  output logic                          HWRITE,
  output logic [1:0]                    HTRANS,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [DATA_W-1:0]             HWDATA,
  output logic [MASTER_W-1:0]           HMASTERD,
  output logic                          HDATAVLD,
`ifdef AHB_M2S_LOCK_EN
  input  logic [NUM_MASTERS-1:0]        HMASTLOCKx,
  output logic                          HMASTLOCK,
  output logic                          HMASTLOCKD,
`endif
  output logic                          HSELERR
);

  localparam logic [MASTER_W-1:0] DEF_SEL = MASTER_W'(DEFAULT_MASTER);
  localparam logic [31:0]         NUM_M   = 32'(NUM_MASTERS);

  logic                   sel_valid_s;
  logic [MASTER_W-1:0]    sel_eff_s;
  logic [NUM_MASTERS-1:0] addr_hit_s;
  logic [NUM_MASTERS-1:0] data_hit_s;

  logic [ADDR_W-1:0]      haddr_mux_s;
  logic                   hwrite_mux_s;
  logic [1:0]             htrans_mux_s;
  logic [2:0]             hsize_mux_s;
  logic [2:0]             hburst_mux_s;
  logic [DATA_W-1:0]      hwdata_mux_s;
  logic [1:0]             htrans_s;

  logic [MASTER_W-1:0]    hmasterd_r;
  logic                   hdatavld_r;
  logic                   hselerr_r;

  assign sel_valid_s = (32'(HMASTER) < NUM_M);
  assign sel_eff_s   = sel_valid_s ? HMASTER : DEF_SEL;

  // One-hot decode of the address-phase and data-phase owners; the AND-OR
  // mux built on these can never pick an undefined slice.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_hit
    assign addr_hit_s[i] = (sel_eff_s  == MASTER_W'(i));
    assign data_hit_s[i] = (hmasterd_r == MASTER_W'(i));
  end

  // AND-OR mux of the address/control fields and of the write data.
  always_comb begin
    haddr_mux_s  = '0;
    hwrite_mux_s = 1'b0;
    htrans_mux_s = 2'b00;
    hsize_mux_s  = 3'b000;
    hburst_mux_s = 3'b000;
    hwdata_mux_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      haddr_mux_s  = haddr_mux_s  | ({ADDR_W{addr_hit_s[i]}} & HADDRx[i*ADDR_W +: ADDR_W]);
      hwrite_mux_s = hwrite_mux_s | (addr_hit_s[i] & HWRITEx[i]);
      htrans_mux_s = htrans_mux_s | ({2{addr_hit_s[i]}} & HTRANSx[i*2 +: 2]);
      hsize_mux_s  = hsize_mux_s  | ({3{addr_hit_s[i]}} & HSIZEx[i*3 +: 3]);
      hburst_mux_s = hburst_mux_s | ({3{addr_hit_s[i]}} & HBURSTx[i*3 +: 3]);
      hwdata_mux_s = hwdata_mux_s | ({DATA_W{data_hit_s[i]}} & HWDATAx[i*DATA_W +: DATA_W]);
    end
  end

  // A bad select must never start a transfer: force IDLE on the slave side.
  always_comb begin
    htrans_s = 2'b00;
    if (sel_valid_s) begin
      htrans_s = htrans_mux_s;
    end else begin
      htrans_s = 2'b00;
    end
  end

  // Data-phase owner, data-valid flag and bad-select pulse, advanced on HREADY.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmasterd_r <= DEF_SEL;
      hdatavld_r <= 1'b0;
      hselerr_r  <= 1'b0;
    end else if (HREADY) begin
      hmasterd_r <= sel_eff_s;
      hdatavld_r <= htrans_s[1];
      hselerr_r  <= ~sel_valid_s;
    end else begin
      hmasterd_r <= hmasterd_r;
      hdatavld_r <= hdatavld_r;
      hselerr_r  <= 1'b0;
    end
  end

  assign HADDR    = haddr_mux_s;
  assign HWRITE   = hwrite_mux_s;
  assign HTRANS   = htrans_s;
  assign HSIZE    = hsize_mux_s;
  assign HBURST   = hburst_mux_s;
  assign HWDATA   = hwdata_mux_s;
  assign HMASTERD = hmasterd_r;
  assign HDATAVLD = hdatavld_r;
  assign HSELERR  = hselerr_r;

`ifdef AHB_M2S_LOCK_EN
  logic hmastlock_s;
  logic hmastlockd_r;

  // Lock follows the selected master like HWRITE, but is dropped on a bad select.
  always_comb begin
    hmastlock_s = 1'b0;
    if (sel_valid_s) begin
      hmastlock_s = |(addr_hit_s & HMASTLOCKx);
    end else begin
      hmastlock_s = 1'b0;
    end
  end

  // Data-phase copy of the lock flag, advanced on HREADY.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hmastlockd_r <= 1'b0;
    end else if (HREADY) begin
      hmastlockd_r <= hmastlock_s;
    end else begin
      hmastlockd_r <= hmastlockd_r;
    end
  end

  assign HMASTLOCK  = hmastlock_s;
  assign HMASTLOCKD = hmastlockd_r;
`endif

endmodule

// File: doc/ahb_mux_m2s_param.md
Name: ahb_mux_m2s_param

Overview:
- Parametrised master-to-slave multiplexer for the AHB bus matrix; successor to the fixed 4-master mux.
- Routes address/control from the address-phase master (HMASTER) to the slave-side bus.
- Tracks the data-phase master internally: registers HMASTER on HREADY, so no external HMASTERD is needed. Steers HWDATA from that registered owner.
- Handles out-of-range master selects safely and flags them.

Parameters:
- NUM_MASTERS, 4, number of master ports (1..16).
- DEFAULT_MASTER, 1, master index driven when no valid master is selected; must be < NUM_MASTERS.
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA width.
- MASTER_W, 4, width of HMASTER/HMASTERD; must satisfy 2^MASTER_W >= NUM_MASTERS.

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HADDRx  in  NUM_MASTERS*ADDR_W  packed master addresses; master i at [i*ADDR_W +: ADDR_W].
- HWRITEx  in  NUM_MASTERS  packed write flags.
- HTRANSx  in  NUM_MASTERS*2  packed transfer types.
- HSIZEx  in  NUM_MASTERS*3  packed sizes.
- HBURSTx  in  NUM_MASTERS*3  packed burst types.
- HWDATAx  in  NUM_MASTERS*DATA_W  packed write data.
- HMASTER  in  MASTER_W  address-phase master select from arbiter.
- HREADY  in  1  bus ready (transfer-complete) from slave-to-master mux.
- HADDR  out  ADDR_W  muxed address.
- HWRITE  out  1  muxed write flag.
- HTRANS  out  2  muxed transfer type.
- HSIZE  out  3  muxed size.
- HBURST  out  3  muxed burst.
- HWDATA  out  DATA_W  muxed write data, selected by HMASTERD.
- HMASTERD  out  MASTER_W  registered data-phase master.
- HDATAVLD  out  1  registered: current data phase carries a real (NONSEQ/SEQ) transfer.
- HSELERR  out  1  registered one-cycle pulse: an out-of-range HMASTER was accepted.

Behaviour:
- Address mux (combinational):
  - HMASTER < NUM_MASTERS: outputs = that master's HADDR/HWRITE/HTRANS/HSIZE/HBURST.
  - HMASTER >= NUM_MASTERS: outputs = DEFAULT_MASTER's fields, except HTRANS forced to 2'b00 (IDLE).
- Effective select sel_eff = HMASTER if in range, else DEFAULT_MASTER.
- HMASTERD register:
  - Reset value = DEFAULT_MASTER.
  - On HCLK rising edge with HREADY=1: HMASTERD <= sel_eff.
  - HREADY=0: hold; wait states keep the data-phase owner.
  - Latency: data-phase owner appears exactly one accepted cycle after the address phase.
- HDATAVLD register:
  - Reset value 0.
  - HREADY=1: HDATAVLD <= HTRANS_out[1] (1 for NONSEQ/SEQ, 0 for IDLE/BUSY).
  - HREADY=0: hold.
- HSELERR register:
  - Reset value 0.
  - HREADY=1 and HMASTER >= NUM_MASTERS: HSELERR <= 1.
  - Otherwise HSELERR <= 0 (single-cycle pulse per accepted bad select).
- HWDATA (combinational): HWDATAx slice indexed by HMASTERD. HMASTERD is always in range by construction.
- Master handover on the same edge HREADY=1: address outputs switch immediately to the new HMASTER. HWDATA keeps the old owner until the edge, then follows the new HMASTERD.
- Reset asserted mid-transfer: all registers clear asynchronously, regardless of HCLK.
  - HWDATA immediately follows DEFAULT_MASTER.
  - Address outputs remain purely combinational.
- No X propagation: every select value yields defined outputs.
- NUM_MASTERS=1 is legal: every in-range select is master 0.

Optional Feature:
- Macro AHB_M2S_LOCK_EN.
- Defined:
  - Adds port HMASTLOCKx (in, NUM_MASTERS) and output HMASTLOCK, muxed like HWRITE; forced 0 when the select is out of range.
  - Adds registered output HMASTLOCKD: reset 0, loads HMASTLOCK when HREADY=1, holds otherwise.
- Undefined: none of these ports or registers exist; all other behaviour identical.

Test Plan:
- Reset: HRESETn=0 with HCLK toggling -> HMASTERD=1, HDATAVLD=0, HSELERR=0, HWDATA=HWDATAx slice 1.
- Basic routing: HMASTER=2, HTRANSx2=NONSEQ, HADDRx2=32'h2000_0010, HREADY=1 -> HADDR=32'h2000_0010 same cycle. Next cycle HMASTERD=2, HDATAVLD=1, HWDATA=HWDATAx2.
- Wait states: HMASTER=0 accepted, then HMASTER=3 with HREADY=0 for 3 cycles -> HMASTERD stays 0 and HWDATA=HWDATAx0 throughout. First HREADY=1 edge -> HMASTERD=3.
- Out-of-range: NUM_MASTERS=4, HMASTER=4'h9, HTRANSx1=SEQ, HREADY=1 -> HADDR=HADDRx1, HTRANS=00. Next cycle HMASTERD=1, HDATAVLD=0, HSELERR=1 for exactly one cycle.
- Async reset mid-burst: HMASTERD=3, HDATAVLD=1, drop HRESETn between clock edges -> both clear before the next HCLK edge.
- Lock (AHB_M2S_LOCK_EN): HMASTER=2, HMASTLOCKx[2]=1, HREADY=1 -> HMASTLOCK=1 immediately, HMASTLOCKD=1 next cycle. HMASTER=7 -> HMASTLOCK=0.
